// File: rtl/convert_8_32.sv
// rtl/convert_8_32.sv - byte-to-word packer, 4 x 8-bit bytes into one 32-bit word
//
// Purpose:
//   Accepts bytes on a valid/ready handshake, assembles every four accepted
//   bytes into a 32-bit word and presents it on a valid/ready output handshake.
//   All handshake outputs are registered: o_rrdy depends only on state, never
//   combinationally on i_trdy.
//
// Parameters:
//   BIG_ENDIAN  0: first byte -> o_data[7:0]; 1: first byte -> o_data[31:24]
//
// Ports:
//   clk         in   1   clock, rising edge
//   reset_n     in   1   asynchronous active-low reset
//   i_data      in   8   input byte
//   i_rval      in   1   input byte valid
//   o_rrdy      out  1   ready for an input byte (high in FILL)
//   o_data      out  32  assembly register / output word
//   o_tval      out  1   output word valid (high in SEND)
//   i_trdy      in   1   downstream ready for a word
//   o_byte_cnt  out  2   bytes held in the partial word
//   i_flush     in   1   (CONVERT_8_32_FLUSH_EN) emit the partial word
//   o_bmask     out  4   (CONVERT_8_32_FLUSH_EN) byte-valid mask, bit n <-> o_data[8n+7:8n]
//
// Configuration macro: CONVERT_8_32_FLUSH_EN

module convert_8_32 #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  i_data,
  input  logic        i_rval,
  output logic        o_rrdy,
  output logic [31:0] o_data,
  output logic        o_tval,
  input  logic        i_trdy,
  output logic [1:0]  o_byte_cnt
`ifdef CONVERT_8_32_FLUSH_EN
  ,
  input  logic        i_flush,
  output logic [3:0]  o_bmask
`endif
);

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state;

  logic        i_xfer;
  logic [1:0]  lane;
  logic [31:0] data_wr;
  logic [2:0]  fill_cnt;
  logic        full;
  logic        flush_go;

  // o_rrdy is only high in FILL, so i_xfer can only happen in FILL.
  assign i_xfer   = i_rval & o_rrdy;
  assign lane     = BIG_ENDIAN ? (2'd3 - o_byte_cnt) : o_byte_cnt;
  assign fill_cnt = {1'b0, o_byte_cnt} + {2'b00, i_xfer};
  // Byte count reaching 4 means the current transfer completes the word.
  assign full     = fill_cnt[2];

  always_comb begin
    data_wr = o_data;
    if (i_xfer) begin
      data_wr[{lane, 3'b000} +: 8] = i_data;
    end
  end

`ifdef CONVERT_8_32_FLUSH_EN
  logic [3:0] flush_mask;

  // A flush only does something when 1..3 bytes would be held after this
  // cycle; a full word takes the normal path and an empty one is ignored.
  assign flush_go = i_flush & (fill_cnt != 3'd0) & ~full;

  always_comb begin
    flush_mask = 4'b0000;
    case (fill_cnt)
      3'd1:    flush_mask = BIG_ENDIAN ? 4'b1000 : 4'b0001;
      3'd2:    flush_mask = BIG_ENDIAN ? 4'b1100 : 4'b0011;
      3'd3:    flush_mask = BIG_ENDIAN ? 4'b1110 : 4'b0111;
      default: flush_mask = 4'b0000;
    endcase
  end
`else
  assign flush_go = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FILL;
      o_tval     <= 1'b0;
      o_rrdy     <= 1'b1;
      o_data     <= 32'h0;
      o_byte_cnt <= 2'd0;
`ifdef CONVERT_8_32_FLUSH_EN
      o_bmask    <= 4'h0;
`endif
    end else begin
      case (state)
        FILL: begin
          o_data <= data_wr;
          if (full || flush_go) begin
            state      <= SEND;
            o_tval     <= 1'b1;
            o_rrdy     <= 1'b0;
            o_byte_cnt <= 2'd0;
`ifdef CONVERT_8_32_FLUSH_EN
            o_bmask    <= full ? 4'hF : flush_mask;
`endif
          end else begin
            o_byte_cnt <= fill_cnt[1:0];
          end
        end
        SEND: begin
          // Word and mask hold until the downstream takes them; the
          // assembly register is cleared so unwritten lanes read as 0.
          if (i_trdy) begin
            state  <= FILL;
            o_tval <= 1'b0;
            o_rrdy <= 1'b1;
            o_data <= 32'h0;
`ifdef CONVERT_8_32_FLUSH_EN
            o_bmask <= 4'h0;
`endif
          end
        end
      endcase
    end
  end

endmodule
